// File: rtl/sram_sched_pkg.sv
// sram_sched_pkg: slot encoding and frame geometry shared by the SRAM scheduler files
package sram_sched_pkg;
    typedef enum logic [1:0] {
        SLOT_WR    = 2'd0,
        SLOT_WHOLD = 2'd1,
        SLOT_RD    = 2'd2,
        SLOT_RCAP  = 2'd3
    } slot_t;
    localparam int DISP_W   = 480;
    localparam int DISP_H   = 272;
    localparam int MAX_ADDR = DISP_W * DISP_H;
endpackage

// File: rtl/sram_wr_fifo.sv
// sram_wr_fifo: synchronous {addr,data} write FIFO with flush
// Ports: clk/rst (sync, active high), flush empties the FIFO (wins over push),
// push/push_addr/push_data enqueue when not full, pop dequeues when not empty,
// head_addr/head_data show the oldest entry, empty and count report occupancy.
module sram_wr_fifo #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic [CW-1:0]     count
);
    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic full, do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign {head_addr, head_data} = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {push_addr, push_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sram_access_scheduler.sv
// sram_access_scheduler: 4-slot time multiplexer of the pixel SRAM between writers and LCD scan-out
// Ports: mco/rst clock and sync reset; i_wr_* / o_wr_ready pixel write handshake into a FIFO;
// i_clr_req / o_clr_busy / o_clr_done full-frame clear; i_disp_on, i_rd_addr, o_rd_data,
// o_rd_valid scan-out read; o_slot current phase; o_sram_* / i_sram_rdata SRAM pins.
// All SRAM pins are registered, so the values driven during o_slot==k belong to slot k.
module sram_access_scheduler #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 24,
    parameter int MAX_ADDR   = sram_sched_pkg::MAX_ADDR,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              mco,
    input  logic              rst,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    input  logic              i_disp_on,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [1:0]        o_slot,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_sram_wdata_oe,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n
);
    import sram_sched_pkg::*;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    slot_t             slot, slot_n;
    logic              clr_busy, clr_busy_n, clr_done_n, clr_go;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_n, addr_n, head_addr;
    logic [DATA_W-1:0] wdata_n, head_data, rd_cap, rd_cap_n, rd_data_n;
    logic              we_n_n, oe_n_n, wdata_oe_n, rd_valid_n;
    logic              fifo_pop, fifo_empty;
    logic [CW-1:0]     fifo_count;
    assign o_wr_ready = fifo_count != CW'(FIFO_DEPTH);
    assign o_clr_busy = clr_busy;
    assign o_slot     = slot;
    sram_wr_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (mco),
        .rst      (rst),
        .flush    (clr_go),
        .push     (i_wr_valid),
        .push_addr(i_wr_addr),
        .push_data(i_wr_data),
        .pop      (fifo_pop),
        .head_addr(head_addr),
        .head_data(head_data),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );
    // Next-state logic prepares the pin values for the slot that follows the current one.
    always_comb begin
        slot_n     = slot_t'(slot + 2'd1);
        clr_go     = i_clr_req && !clr_busy;
        // The FIFO head is consumed on the edge that enters the write slot; a clear
        // starting on that same edge flushes it instead.
        fifo_pop   = slot == SLOT_RCAP && !clr_busy && !clr_go && !fifo_empty;
        clr_busy_n = clr_go ? 1'b1 : clr_busy;
        clr_cnt_n  = clr_go ? '0 : clr_cnt;
        clr_done_n = 1'b0;
        addr_n     = o_sram_addr;
        wdata_n    = o_sram_wdata;
        we_n_n     = 1'b1;
        oe_n_n     = o_sram_oe_n;
        wdata_oe_n = o_sram_wdata_oe;
        rd_cap_n   = rd_cap;
        rd_data_n  = o_rd_data;
        rd_valid_n = 1'b0;
        case (slot)
            SLOT_RCAP: begin
                oe_n_n     = 1'b1;
                rd_data_n  = rd_cap;
                rd_valid_n = 1'b1;
                wdata_oe_n = 1'b0;
                if (clr_busy) begin
                    addr_n     = clr_cnt;
                    wdata_n    = '0;
                    we_n_n     = 1'b0;
                    wdata_oe_n = 1'b1;
                    clr_cnt_n  = clr_cnt + 1'b1;
                end else if (fifo_pop && head_addr < ADDR_W'(MAX_ADDR)) begin
                    addr_n     = head_addr;
                    wdata_n    = head_data;
                    we_n_n     = 1'b0;
                    wdata_oe_n = 1'b1;
                end
            end
            SLOT_WR: begin
                // clr_cnt has already moved past the last word once its write slot is on the pins.
                if (clr_busy && clr_cnt == ADDR_W'(MAX_ADDR)) begin
                    clr_busy_n = 1'b0;
                    clr_done_n = 1'b1;
                end
            end
            SLOT_WHOLD: begin
                addr_n     = i_rd_addr;
                wdata_oe_n = 1'b0;
                oe_n_n     = !i_disp_on;
            end
            default: begin
                // Sample the bus while OE is still asserted; it is released for slot 3.
                rd_cap_n = i_disp_on ? i_sram_rdata : '0;
                oe_n_n   = 1'b1;
            end
        endcase
    end
    always_ff @(posedge mco) begin
        if (rst) begin
            slot            <= SLOT_WR;
            clr_busy        <= 1'b0;
            clr_cnt         <= '0;
            o_clr_done      <= 1'b0;
            o_sram_addr     <= '0;
            o_sram_wdata    <= '0;
            o_sram_we_n     <= 1'b1;
            o_sram_oe_n     <= 1'b1;
            o_sram_wdata_oe <= 1'b0;
            rd_cap          <= '0;
            o_rd_data       <= '0;
            o_rd_valid      <= 1'b0;
        end else begin
            slot            <= slot_n;
            clr_busy        <= clr_busy_n;
            clr_cnt         <= clr_cnt_n;
            o_clr_done      <= clr_done_n;
            o_sram_addr     <= addr_n;
            o_sram_wdata    <= wdata_n;
            o_sram_we_n     <= we_n_n;
            o_sram_oe_n     <= oe_n_n;
            o_sram_wdata_oe <= wdata_oe_n;
            rd_cap          <= rd_cap_n;
            o_rd_data       <= rd_data_n;
            o_rd_valid      <= rd_valid_n;
        end
    end
endmodule

// File: tb/tb_sram_access_scheduler.sv
// tb_sram_access_scheduler: directed checks of slot schedule, writes, drops, clear and reset
// A reduced frame size keeps the full clear short; the drop boundary is TB_MAX itself.
module tb_sram_access_scheduler;
    localparam int TB_MAX = 256;
    logic        mco = 1'b0;
    logic        rst;
    logic        i_wr_valid;
    logic [17:0] i_wr_addr;
    logic [23:0] i_wr_data;
    logic        o_wr_ready;
    logic        i_clr_req;
    logic        o_clr_busy;
    logic        o_clr_done;
    logic        i_disp_on;
    logic [17:0] i_rd_addr;
    logic [23:0] o_rd_data;
    logic        o_rd_valid;
    logic [1:0]  o_slot;
    logic [17:0] o_sram_addr;
    logic [23:0] o_sram_wdata;
    logic        o_sram_wdata_oe;
    logic [23:0] i_sram_rdata;
    logic        o_sram_we_n;
    logic        o_sram_oe_n;
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    sram_access_scheduler #(.MAX_ADDR(TB_MAX)) dut (
        .mco(mco), .rst(rst),
        .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .i_clr_req(i_clr_req), .o_clr_busy(o_clr_busy), .o_clr_done(o_clr_done),
        .i_disp_on(i_disp_on), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_slot(o_slot), .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata),
        .o_sram_wdata_oe(o_sram_wdata_oe), .i_sram_rdata(i_sram_rdata),
        .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n)
    );
    always #5 mco = ~mco;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge mco);
        #1;
        cyc++;
    endtask
    task automatic align(input int s);
        while (cyc % 4 != s) step();
    endtask
    task automatic push(input logic [17:0] a, input logic [23:0] d);
        int n;
        n = 0;
        i_wr_valid = 1'b1;
        i_wr_addr  = a;
        i_wr_data  = d;
        while (!o_wr_ready && n < 20) begin
            step();
            n++;
        end
        chk("push_ready", o_wr_ready, 1);
        step();
        i_wr_valid = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        int s, good, badw, busy_cycles, done_cnt, wl;
        logic [17:0] exp_a;
        logic seen;
        rst = 1'b1; i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_clr_req = 1'b0;
        i_disp_on = 1'b1; i_rd_addr = 18'h00123; i_sram_rdata = 24'hA5A5A5;
        repeat (3) @(posedge mco);
        #1;
        rst = 1'b0;
        cyc = 0;
        chk("rst_slot", o_slot, 0);
        chk("rst_ready", o_wr_ready, 1);
        chk("rst_busy", o_clr_busy, 0);
        chk("rst_done", o_clr_done, 0);
        chk("rst_rv", o_rd_valid, 0);
        chk("rst_rd", o_rd_data, 0);
        chk("rst_we", o_sram_we_n, 1);
        chk("rst_oe", o_sram_oe_n, 1);
        chk("rst_doe", o_sram_wdata_oe, 0);
        chk("rst_addr", o_sram_addr, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            s = cyc % 4;
            chk("idle_slot", o_slot, s);
            chk("idle_oe", o_sram_oe_n, s != 2);
            chk("idle_we", o_sram_we_n, 1);
            chk("idle_rv", o_rd_valid, s == 0);
            if (s == 0) chk("idle_rd", o_rd_data, 24'hA5A5A5);
            if (s == 2) chk("idle_addr", o_sram_addr, 18'h00123);
        end
        i_disp_on = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            s = cyc % 4;
            chk("off_oe", o_sram_oe_n, 1);
            chk("off_rv", o_rd_valid, s == 0);
            if (s == 0) chk("off_rd", o_rd_data, 0);
        end
        i_disp_on = 1'b1;
        align(3);
        for (int i = 0; i < 4; i++) push(18'(10 + i), 24'(32'h111111 * (i + 1)));
        chk("full_ready", o_wr_ready, 0);
        chk("full_slot", o_slot, 3);
        i_wr_valid = 1'b1; i_wr_addr = 18'd14; i_wr_data = 24'h555555;
        step();
        chk("ready_back", o_wr_ready, 1);
        chk("wr0_slot", o_slot, 0);
        chk("wr0_we", o_sram_we_n, 0);
        chk("wr0_doe", o_sram_wdata_oe, 1);
        chk("wr0_addr", o_sram_addr, 10);
        chk("wr0_data", o_sram_wdata, 24'h111111);
        step();
        i_wr_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            chk("hold_we", o_sram_we_n, 1);
            chk("hold_doe", o_sram_wdata_oe, 1);
            chk("hold_addr", o_sram_addr, 32'(10 + i - 1));
            step();
            chk("rd_doe", o_sram_wdata_oe, 0);
            chk("rd_addr", o_sram_addr, 18'h00123);
            step();
            step();
            chk("wr_we", o_sram_we_n, 0);
            chk("wr_addr", o_sram_addr, 32'(10 + i));
            chk("wr_data", o_sram_wdata, 32'h111111 * (i + 1));
            step();
        end
        push(18'(TB_MAX), 24'hDEAD01);
        push(18'd7, 24'h070707);
        push(18'(TB_MAX - 1), 24'h0FF0FF);
        chk("drop_slot", o_slot, 0);
        chk("drop_we", o_sram_we_n, 1);
        chk("drop_doe", o_sram_wdata_oe, 0);
        repeat (4) step();
        chk("a7_we", o_sram_we_n, 0);
        chk("a7_addr", o_sram_addr, 7);
        chk("a7_data", o_sram_wdata, 24'h070707);
        repeat (4) step();
        chk("last_we", o_sram_we_n, 0);
        chk("last_addr", o_sram_addr, TB_MAX - 1);
        chk("last_data", o_sram_wdata, 24'h0FF0FF);
        repeat (4) step();
        push(18'd20, 24'h777777);
        push(18'd21, 24'h777777);
        i_clr_req = 1'b1;
        step();
        i_clr_req = 1'b0;
        chk("clr_busy", o_clr_busy, 1);
        good = 0; badw = 0; busy_cycles = 1; done_cnt = 0; exp_a = '0; seen = 1'b0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            step();
            if (o_clr_busy) busy_cycles++;
            if (o_clr_done) begin
                done_cnt++;
                seen = 1'b1;
            end
            if (!o_sram_we_n) begin
                if (o_sram_addr == exp_a && o_sram_wdata == 24'h0) begin
                    good++;
                    exp_a++;
                end else badw++;
            end
            i_clr_req = k == 400;
            if (k == 410) begin
                i_wr_valid = 1'b1; i_wr_addr = 18'd30; i_wr_data = 24'hABCDEF;
            end else i_wr_valid = 1'b0;
        end
        chk("clr_done_seen", seen, 1);
        chk("clr_busy_fall", o_clr_busy, 0);
        chk("clr_words", good, TB_MAX);
        chk("clr_badwr", badw, 0);
        chk("clr_len", busy_cycles, 4 * TB_MAX - 2);
        repeat (3) begin
            step();
            if (o_clr_done) done_cnt++;
        end
        chk("clr_done_cnt", done_cnt, 1);
        chk("post_slot", o_slot, 0);
        chk("post_we", o_sram_we_n, 0);
        chk("post_addr", o_sram_addr, 30);
        chk("post_data", o_sram_wdata, 24'hABCDEF);
        i_clr_req = 1'b1;
        step();
        i_clr_req = 1'b0;
        repeat (400) step();
        chk("rc_busy", o_clr_busy, 1);
        push(18'd40, 24'h404040);
        rst = 1'b1;
        step();
        chk("rc_busy0", o_clr_busy, 0);
        chk("rc_we", o_sram_we_n, 1);
        chk("rc_oe", o_sram_oe_n, 1);
        chk("rc_doe", o_sram_wdata_oe, 0);
        chk("rc_ready", o_wr_ready, 1);
        chk("rc_slot", o_slot, 0);
        rst = 1'b0;
        cyc = 0;
        wl = 0; done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rel_slot", o_slot, cyc % 4);
            if (!o_sram_we_n) wl++;
            if (o_clr_done) done_cnt++;
        end
        chk("rel_no_write", wl, 0);
        chk("rel_no_done", done_cnt, 0);
        chk("rel_busy", o_clr_busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
